// File: rtl/gcd_arbiter.sv
// Round-robin front end that time-shares one GCD engine among NReq requesters,
// with a watchdog that aborts engine runs that never report ready.
module gcd_arbiter #(
   parameter int NBits         = 8,
   parameter int NReq          = 4,
   parameter int TimeoutCycles = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NReq-1:0]         req,
   input  logic [NReq*NBits-1:0]   x_in,
   input  logic [NReq*NBits-1:0]   y_in,
   output logic [NReq-1:0]         grant,
   output logic [NReq-1:0]         done,
   output logic [NBits-1:0]        res,
   output logic                    err,
   output logic                    busy,
   output logic [NBits-1:0]        eng_xi,
   output logic [NBits-1:0]        eng_yi,
   output logic                    eng_start,
   output logic                    eng_rst,
   input  logic [NBits-1:0]        eng_xo,
   input  logic                    eng_rdy
);

   localparam int IdxW = $clog2(NReq);
   localparam int CntW = $clog2(TimeoutCycles);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StStart,
      StWait,
      StRespond
   } state_t;

   state_t            state_q;
   logic [IdxW-1:0]   ptr_q;
   logic [IdxW-1:0]   winner_q;
   logic [NReq-1:0]   grant_q;
   logic [NReq-1:0]   done_q;
   logic [NBits-1:0]  res_q;
   logic [NBits-1:0]  xi_q;
   logic [NBits-1:0]  yi_q;
   logic              err_q;
   logic              busy_q;
   logic              start_q;
   logic              abort_q;
   logic [CntW-1:0]   cnt_q;

   logic              winValid_d;
   logic [IdxW-1:0]   winIdx_d;
   logic [IdxW:0]     scanIdx;
   logic [NBits-1:0]  selX_d;
   logic [NBits-1:0]  selY_d;
   logic [IdxW-1:0]   ptr_d;

   // Scan requests starting at the rotating pointer; the first hit wins.
   always_comb begin
      winValid_d = 1'b0;
      winIdx_d   = '0;
      scanIdx    = '0;
      for (int k = 0; k < NReq; k++) begin
         scanIdx = {1'b0, ptr_q} + (IdxW+1)'(k);
         if (scanIdx >= (IdxW+1)'(NReq)) begin
            scanIdx = scanIdx - (IdxW+1)'(NReq);
         end
         if (!winValid_d && req[scanIdx[IdxW-1:0]]) begin
            winValid_d = 1'b1;
            winIdx_d   = scanIdx[IdxW-1:0];
         end
      end
   end

   always_comb begin
      selX_d = '0;
      selY_d = '0;
      for (int i = 0; i < NReq; i++) begin
         if (winIdx_d == IdxW'(i)) begin
            selX_d = x_in[i*NBits +: NBits];
            selY_d = y_in[i*NBits +: NBits];
         end
      end
   end

   assign ptr_d = (int'(winner_q) == NReq-1) ? '0 : winner_q + 1'b1;

   // Single sequencer: every output except eng_rst comes straight from a register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         ptr_q    <= '0;
         winner_q <= '0;
         grant_q  <= '0;
         done_q   <= '0;
         res_q    <= '0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         xi_q     <= '0;
         yi_q     <= '0;
         start_q  <= 1'b0;
         abort_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (winValid_d) begin
                  winner_q <= winIdx_d;
                  grant_q  <= {{(NReq-1){1'b0}}, 1'b1} << winIdx_d;
                  xi_q     <= selX_d;
                  yi_q     <= selY_d;
                  busy_q   <= 1'b1;
                  state_q  <= StLoad;
               end
            end
            StLoad: begin
               start_q <= 1'b1;
               state_q <= StStart;
            end
            StStart: begin
               start_q <= 1'b0;
               cnt_q   <= '0;
               state_q <= StWait;
            end
            StWait: begin
               // A real completion in the last allowed cycle still beats the watchdog.
               if (eng_rdy) begin
                  res_q   <= eng_xo;
                  err_q   <= 1'b0;
                  done_q  <= grant_q;
                  state_q <= StRespond;
               end else if (cnt_q == CntW'(TimeoutCycles-1)) begin
                  res_q   <= '0;
                  err_q   <= 1'b1;
                  abort_q <= 1'b1;
                  done_q  <= grant_q;
                  state_q <= StRespond;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StRespond: begin
               grant_q <= '0;
               done_q  <= '0;
               res_q   <= '0;
               err_q   <= 1'b0;
               abort_q <= 1'b0;
               busy_q  <= 1'b0;
               xi_q    <= '0;
               yi_q    <= '0;
               ptr_q   <= ptr_d;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign grant     = grant_q;
   assign done      = done_q;
   assign res       = res_q;
   assign err       = err_q;
   assign busy      = busy_q;
   assign eng_xi    = xi_q;
   assign eng_yi    = yi_q;
   assign eng_start = start_q;
   assign eng_rst   = rst | abort_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Testbench for gcd_arbiter: behavioural engine stub, transaction-level timeline
// model checked every cycle, and directed scenarios with hand-computed results.
module tb_gcd_arbiter;

   localparam int NBits = 8;
   localparam int NReq  = 4;
   localparam int Tmo   = 8;

   logic                  clk  = 1'b0;
   logic                  rst  = 1'b1;
   logic [NReq-1:0]       req  = '0;
   logic [NReq*NBits-1:0] xIn  = '0;
   logic [NReq*NBits-1:0] yIn  = '0;
   logic [NReq-1:0]       grant, done;
   logic [NBits-1:0]      res, engXi, engYi, engXo;
   logic                  err, busy, engStart, engRstW, engRdy;

   int nChecks = 0;
   int nFails  = 0;
   int cyc     = 0;

   gcd_arbiter #(.NBits(NBits), .NReq(NReq), .TimeoutCycles(Tmo)) dut (
      .clk(clk), .rst(rst), .req(req), .x_in(xIn), .y_in(yIn),
      .grant(grant), .done(done), .res(res), .err(err), .busy(busy),
      .eng_xi(engXi), .eng_yi(engYi), .eng_start(engStart), .eng_rst(engRstW),
      .eng_xo(engXo), .eng_rdy(engRdy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   function automatic logic [7:0] gcdRef(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, q, t;
      if (a == 0 || b == 0) return 8'd0;
      p = a;
      q = b;
      while (q != 0) begin
         t = p % q;
         p = q;
         q = t;
      end
      return p;
   endfunction

   // Engine stub: fixed or random latency, optional stall, optional stray ready pulses while idle.
   logic stallMode = 1'b0, randStall = 1'b0, spurEn = 1'b0, spurForce = 1'b0;
   int   forceLat  = -1;
   logic engBusy, engStall;
   int   engCnt;
   logic [7:0] engRes;

   always @(posedge clk or posedge engRstW) begin
      if (engRstW) begin
         engBusy <= 1'b0; engStall <= 1'b0; engCnt <= 0;
         engRdy <= 1'b0; engXo <= '0; engRes <= '0;
      end else begin
         engRdy <= 1'b0;
         if (engBusy) begin
            if (!engStall) begin
               if (engCnt == 0) begin
                  engRdy <= 1'b1; engXo <= engRes; engBusy <= 1'b0;
               end else begin
                  engCnt <= engCnt - 1;
               end
            end
         end else if (engStart) begin
            engBusy  <= 1'b1;
            engRes   <= gcdRef(engXi, engYi);
            engCnt   <= (forceLat >= 0) ? forceLat : int'($urandom_range(0, 5));
            engStall <= stallMode || (randStall && ($urandom_range(0, 7) == 0));
         end else if (spurForce || (spurEn && $urandom_range(0, 3) == 0)) begin
            engRdy <= 1'b1;
            engXo  <= spurForce ? 8'hA5 : 8'($urandom);
         end
      end
   end

   // Timeline model: age counts cycles since the request was accepted in IDLE.
   int mOwner = -1, mAge = 0, mDoneAge = -1, mPtr = 0;
   logic [7:0] mX, mY, mRes;
   logic mErr;
   int logIdx[$], logRes[$], logErr[$];
   int lastStartCyc = 0, lastDoneCyc = 0, engRstCnt = 0;
   logic [NReq-1:0] eGrant, eDone;
   logic [7:0] eRes, eXi, eYi;
   logic eErr, eBusy, eStart, eEngRst;

   always @(negedge clk) begin
      if (rst) begin
         mOwner = -1; mPtr = 0; mDoneAge = -1; mAge = 0;
      end else begin
         eGrant = '0; eDone = '0; eRes = '0; eErr = 1'b0; eBusy = 1'b0;
         eXi = '0; eYi = '0; eStart = 1'b0; eEngRst = 1'b0;
         if (mOwner >= 0) begin
            eGrant = 4'b0001 << mOwner;
            eBusy  = 1'b1;
            eXi    = mX;
            eYi    = mY;
            eStart = (mAge == 2);
            if (mAge == mDoneAge) begin
               eDone = eGrant; eRes = mRes; eErr = mErr; eEngRst = mErr;
            end
         end
         checkOutput("grant", grant, eGrant);
         checkOutput("done", done, eDone);
         checkOutput("res", res, eRes);
         checkOutput("err", err, eErr);
         checkOutput("busy", busy, eBusy);
         checkOutput("engXi", engXi, eXi);
         checkOutput("engYi", engYi, eYi);
         checkOutput("engStart", engStart, eStart);
         checkOutput("engRst", engRstW, eEngRst);

         if (engStart) lastStartCyc = cyc;
         if (engRstW) engRstCnt++;
         if (done != 0) begin
            lastDoneCyc = cyc;
            for (int i = 0; i < NReq; i++) begin
               if (done[i]) begin
                  logIdx.push_back(i); logRes.push_back(int'(res)); logErr.push_back(int'(err));
               end
            end
            req = req & ~done;
         end

         if (mOwner < 0) begin
            for (int k = 0; k < NReq; k++) begin
               if (mOwner < 0 && req[(mPtr + k) % NReq]) mOwner = (mPtr + k) % NReq;
            end
            if (mOwner >= 0) begin
               mAge = 1; mDoneAge = -1;
               mX = xIn[mOwner*NBits +: NBits];
               mY = yIn[mOwner*NBits +: NBits];
            end
         end else begin
            if (mDoneAge < 0 && mAge >= 3) begin
               if (engRdy) begin
                  mDoneAge = mAge + 1; mRes = gcdRef(mX, mY); mErr = 1'b0;
               end else if (mAge == 3 + Tmo - 1) begin
                  mDoneAge = mAge + 1; mRes = '0; mErr = 1'b1;
               end
            end
            if (mAge == mDoneAge) begin
               mPtr = (mOwner + 1) % NReq;
               mOwner = -1;
            end else begin
               mAge++;
            end
         end
      end
   end

   task automatic applyStimulus(input int idx, input logic [7:0] x, input logic [7:0] y);
      xIn[idx*NBits +: NBits] = x;
      yIn[idx*NBits +: NBits] = y;
      req[idx] = 1'b1;
   endtask

   task automatic waitIdle(input int maxCycles);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(req == 0 && busy == 1'b0) && n < maxCycles);
      if (n >= maxCycles) checkOutput("idleTimeout", 32'd1, 32'd0);
   endtask

   task automatic checkLog(input int pos, input int idx, input int r, input int e);
      if (pos >= logIdx.size()) begin
         checkOutput("logMissing", pos, logIdx.size());
      end else begin
         checkOutput("logIdx", logIdx[pos], idx);
         checkOutput("logRes", logRes[pos], r);
         checkOutput("logErr", logErr[pos], e);
      end
   endtask

   task automatic pulseReset();
      @(posedge clk); #3 rst = 1'b1;
      @(posedge clk); #3 rst = 1'b0;
   endtask

   int base;
   int rstBase;

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("rstGrant", grant, 0);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstDone", done, 0);
      checkOutput("rstStart", engStart, 0);
      checkOutput("rstEngRst", engRstW, 1);
      @(posedge clk); #3 rst = 1'b0;
      spurEn = 1'b1;

      // Single requester, latency pinned by literals
      @(posedge clk); #1;
      base = logIdx.size();
      applyStimulus(1, 8'd12, 8'd8);
      @(posedge clk); #2 checkOutput("t1Grant", grant, 4'b0010);
      @(posedge clk); #2 checkOutput("t1Start", engStart, 1);
      waitIdle(40);
      checkLog(base, 1, 4, 0);

      // All four at ptr=0
      pulseReset();
      @(posedge clk); #1;
      base = logIdx.size();
      applyStimulus(0, 8'd9, 8'd6);
      applyStimulus(1, 8'd10, 8'd4);
      applyStimulus(2, 8'd7, 8'd7);
      applyStimulus(3, 8'd15, 8'd5);
      waitIdle(200);
      checkLog(base, 0, 3, 0);
      checkLog(base + 1, 1, 2, 0);
      checkLog(base + 2, 2, 7, 0);
      checkLog(base + 3, 3, 5, 0);

      // Fairness: serve 2, then 0 and 2 together -> 0 first (wrap), then 2
      @(posedge clk); #1;
      base = logIdx.size();
      applyStimulus(2, 8'd8, 8'd12);
      waitIdle(40);
      @(posedge clk); #1;
      applyStimulus(0, 8'd14, 8'd21);
      applyStimulus(2, 8'd18, 8'd24);
      waitIdle(100);
      checkLog(base, 2, 4, 0);
      checkLog(base + 1, 0, 7, 0);
      checkLog(base + 2, 2, 6, 0);

      // Timeout with a stalled engine, then a normal run
      stallMode = 1'b1;
      @(posedge clk); #1;
      base = logIdx.size();
      rstBase = engRstCnt;
      applyStimulus(1, 8'd20, 8'd15);
      waitIdle(60);
      checkLog(base, 1, 0, 1);
      checkOutput("tmoSpan", lastDoneCyc - lastStartCyc, Tmo + 1);
      checkOutput("tmoEngRstCycles", engRstCnt - rstBase, 1);
      stallMode = 1'b0;
      @(posedge clk); #1;
      applyStimulus(1, 8'd20, 8'd15);
      waitIdle(60);
      checkLog(base + 1, 1, 5, 0);

      // Ready in the very last WAIT cycle beats the watchdog
      forceLat = 6;
      @(posedge clk); #1;
      base = logIdx.size();
      applyStimulus(3, 8'd36, 8'd27);
      waitIdle(60);
      checkLog(base, 3, 9, 0);
      checkOutput("lastWaitSpan", lastDoneCyc - lastStartCyc, Tmo + 1);
      forceLat = -1;

      // Asynchronous reset in the middle of WAIT
      stallMode = 1'b1;
      @(posedge clk); #1;
      applyStimulus(2, 8'd6, 8'd4);
      for (int n = 0; n < 20 && !engStart; n++) @(negedge clk);
      checkOutput("t5StartSeen", engStart, 1);
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      checkOutput("arstGrant", grant, 0);
      checkOutput("arstBusy", busy, 0);
      checkOutput("arstDone", done, 0);
      checkOutput("arstStart", engStart, 0);
      checkOutput("arstEngRst", engRstW, 1);
      base = logIdx.size();
      req = '0;
      stallMode = 1'b0;
      applyStimulus(3, 8'd21, 8'd14);
      @(negedge clk);
      @(posedge clk); #3 rst = 1'b0;
      waitIdle(60);
      checkOutput("arstLogCount", logIdx.size() - base, 1);
      checkLog(base, 3, 7, 0);

      // Zero operand while stray ready pulses hit IDLE/LOAD/START
      spurForce = 1'b1;
      @(posedge clk); #1;
      base = logIdx.size();
      applyStimulus(0, 8'd0, 8'd5);
      waitIdle(60);
      checkLog(base, 0, 0, 0);
      spurForce = 1'b0;

      // Randomised traffic with occasional stalls and late operand changes
      randStall = 1'b1;
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         for (int i = 0; i < NReq; i++) begin
            if (!req[i] && $urandom_range(0, 2) == 0) begin
               applyStimulus(i, 8'($urandom_range(0, 60)), 8'($urandom_range(0, 60)));
            end else if (req[i] && mOwner == i && mAge >= 3 && $urandom_range(0, 3) == 0) begin
               xIn[i*NBits +: NBits] = 8'($urandom);
               yIn[i*NBits +: NBits] = 8'($urandom);
            end
         end
      end
      randStall = 1'b0;
      waitIdle(600);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish, failures so far %0d", nFails);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/gcd_arbiter.md
Name: gcd_arbiter

Overview:
Round-robin scheduler that shares one gcd_rtl engine among NReq requesters. It latches the winning requester's operands and sequences the engine's load/start/ready handshake. It returns the result to the winner with a one-cycle done pulse. A watchdog aborts any engine run that does not complete within TimeoutCycles and reports an error.

Parameters:
NBits, 8, operand/result width; must match the engine instance.
NReq, 4, number of requesters; valid range 2..16.
TimeoutCycles, 64, maximum WAIT cycles before abort; must be ≥2.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
req  in  NReq  per-requester request level; held with operands stable until that requester's done.
x_in  in  NReq*NBits  packed operand x; requester i occupies bits [i*NBits +: NBits].
y_in  in  NReq*NBits  packed operand y; same packing as x_in.
grant  out  NReq  one-hot owner of the engine; 0 when idle.
done  out  NReq  one-hot, one-cycle completion pulse.
res  out  NBits  result; valid only while done≠0.
err  out  1  qualifies done: 1 = timeout abort, res=0.
busy  out  1  high whenever state≠IDLE.
eng_xi  out  NBits  engine operand x.
eng_yi  out  NBits  engine operand y.
eng_start  out  1  engine start pulse.
eng_rst  out  1  engine reset = rst OR registered abort pulse.
eng_xo  in  NBits  engine result.
eng_rdy  in  1  engine completion pulse.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; ptr=0; grant, done, res, err, busy, eng_xi, eng_yi, eng_start, abort pulse, timeout counter all 0. eng_rst follows rst combinationally.
- States: IDLE, LOAD, START, WAIT, RESPOND. All outputs are registered except eng_rst.
- IDLE:
  - If req≠0, winner = first set req bit scanning ptr, ptr+1, … with wrap modulo NReq.
  - Register grant=onehot(winner), eng_xi=x_in[winner], eng_yi=y_in[winner]; go to LOAD.
  - If req=0, stay in IDLE with all outputs 0.
- LOAD: one cycle with operands stable and eng_start=0, so the engine samples them in its idle state. Go to START.
- START: eng_start=1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
- WAIT:
  - eng_start=0. eng_rdy is sampled only in this state; eng_rdy in any other state is ignored.
  - If eng_rdy=1: latch res=eng_xo, err=0; go to RESPOND.
  - Else if counter=TimeoutCycles-1: res=0, err=1, abort pulse=1 (eng_rst high for the following cycle); go to RESPOND.
  - Else increment the counter.
- RESPOND:
  - done=grant for one cycle, with res and err valid.
  - ptr ← (winner+1) mod NReq.
  - Next cycle: grant, done, res, err all cleared; state=IDLE.
- Latency: req sampled in IDLE at cycle 0 → grant at cycle 1 → eng_start at cycle 2 → done exactly one cycle after the WAIT cycle in which eng_rdy is seen. Minimum round trip is 5 cycles plus engine time.
- Back-to-back: a req still high in the IDLE cycle after done counts as a new request. The rotated ptr gives other pending requesters priority.
- Requester rules:
  - Dropping req mid-service does not cancel the operation; done is still pulsed.
  - Changes to x_in/y_in after LOAD do not affect the run.
- Arithmetic: no conversion in this block. Operand sign handling and zero-operand results (0) are the engine's responsibility; res passes eng_xo unchanged.
- Reset mid-operation: aborts immediately with no done pulse. The engine is also reset via eng_rst.

Test Plan:
- Single requester: req[1]=1, x=12, y=8 with engine attached → grant=0010 one cycle after req; eng_start two cycles after req; done=0010, res=4, err=0; busy falls the cycle after done.
- All four requesters high simultaneously at ptr=0, operands (9,6),(10,4),(7,7),(15,5) → completion order 0,1,2,3 with res 3,2,7,5; grant never has more than one bit set.
- Fairness: after requester 2 is served, req=0101 held continuously → next grant is requester 0 (wrap past 3), then requester 2.
- Timeout: engine stub that never asserts eng_rdy, TimeoutCycles=8 → done pulses 8 WAIT cycles after eng_start, err=1, res=0, eng_rst high exactly one cycle; the next request is served normally.
- Asynchronous rst asserted mid-WAIT (between clock edges) → grant, busy, and all outputs 0 immediately with no done pulse; after release, a pending req[3] is served from ptr=0.
- Zero operand: x=0, y=5 → done with res=0, err=0; eng_rdy pulses arriving during IDLE/LOAD are ignored.
